// File: rtl/vga_cmd_pkg.sv
// Shared definitions for the VGA command scheduler: opcodes, FSM states, palette field widths.
package vga_cmd_pkg;

   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [3:0] OP_SETPAL  = 4'h1;
   localparam logic [3:0] OP_SETMODE = 4'h2;
   localparam logic [7:0] OP_CLRERR  = 8'hFF;

   localparam int PAL_IDX_W  = 4;
   localparam int PAL_CH_W   = 4;
   localparam int PAL_DATA_W = 3 * PAL_CH_W;
   localparam int MODE_W     = 4;

   typedef enum logic [1:0] {
      S_WAIT    = 2'd0,
      S_ACK     = 2'd1,
      S_WR_PEND = 2'd2
   } state_t;

endpackage

// File: rtl/cmd_timeout.sv
// Inter-byte idle counter: counts enabled cycles, pulses expire on the TIMEOUT-th one and restarts.
// Combinational expire, no backpressure; clr has priority over counting.
module cmd_timeout #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   assign expire = en & (cnt == LAST);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (clr || expire) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_cmd_sched.sv
// Assembles commands from the shared byte register, defers palette writes to blanking, double-buffers mode.
// Read strobe one cycle per byte with an idle cycle between; a pending palette write stalls further reads.
module vga_cmd_sched
   import vga_cmd_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  cmdreg_data_avail,
   input  logic [7:0]            cmdreg_data_recv,
   output logic                  cmdreg_rd,
   input  logic                  blank_in,
   input  logic                  frame_start_in,
   output logic                  pal_wr,
   output logic [PAL_IDX_W-1:0]  pal_waddr,
   output logic [PAL_DATA_W-1:0] pal_wdata,
   output logic [MODE_W-1:0]     mode_out,
   output logic                  busy,
   output logic                  err
);

   state_t                 state, state_nxt;
   logic [7:0]             cmd_byte;
   logic [1:0]             byte_idx;
   logic [PAL_IDX_W-1:0]   pal_idx;
   logic [MODE_W-1:0]      shadow_mode;
   logic                   take, ack, wr_fire;
   logic                   is_nop, is_pal, is_mode, is_clr, is_bad;
   logic                   to_en, to_clr, to_expire;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= S_WAIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:    if (cmdreg_data_avail) state_nxt = S_ACK;
         S_ACK:     state_nxt = (byte_idx == 2'd2) ? S_WR_PEND : S_WAIT;
         S_WR_PEND: if (blank_in) state_nxt = S_WAIT;
         default:   state_nxt = S_WAIT;
      endcase
   end

   always_comb begin
      take    = 1'b0;
      ack     = 1'b0;
      wr_fire = 1'b0;
      case (state)
         S_WAIT:    take    = cmdreg_data_avail;
         S_ACK:     ack     = 1'b1;
         S_WR_PEND: wr_fire = blank_in;
         default:   ;
      endcase
   end

   assign busy = (state != S_WAIT) | (byte_idx != 2'd0);

   // Opcode classes only matter when the latched byte is byte 0 of a command.
   always_comb begin
      is_nop  = (cmd_byte == OP_NOP);
      is_pal  = (cmd_byte[7:4] == OP_SETPAL);
      is_mode = (cmd_byte[7:4] == OP_SETMODE);
      is_clr  = (cmd_byte == OP_CLRERR);
      is_bad  = ~(is_nop | is_pal | is_mode | is_clr);
   end

   assign to_en  = (state == S_WAIT) & (byte_idx != 2'd0) & ~cmdreg_data_avail;
   assign to_clr = ~to_en;

   cmd_timeout #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk    (clk),
      .nrst   (nrst),
      .clr    (to_clr),
      .en     (to_en),
      .expire (to_expire)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cmdreg_rd   <= 1'b0;
         pal_wr      <= 1'b0;
         pal_waddr   <= '0;
         pal_wdata   <= '0;
         mode_out    <= '0;
         err         <= 1'b0;
         cmd_byte    <= '0;
         byte_idx    <= 2'd0;
         pal_idx     <= '0;
         shadow_mode <= '0;
      end else begin
         cmdreg_rd <= take;
         pal_wr    <= wr_fire;
         if (take) cmd_byte <= cmdreg_data_recv;
         if (frame_start_in) mode_out <= shadow_mode;

         if (ack && byte_idx == 2'd0 && is_clr)                   err <= 1'b0;
         else if (to_expire || (ack && byte_idx == 2'd0 && is_bad)) err <= 1'b1;

         if (ack) begin
            case (byte_idx)
               2'd0: begin
                  if (is_pal) begin
                     pal_idx  <= cmd_byte[3:0];
                     byte_idx <= 2'd1;
                  end else if (is_mode) begin
                     shadow_mode <= cmd_byte[3:0];
                  end
               end
               2'd1: begin
                  pal_waddr                       <= pal_idx;
                  pal_wdata[PAL_DATA_W-1:PAL_CH_W] <= cmd_byte;
                  byte_idx                        <= 2'd2;
               end
               default: begin
                  pal_wdata[PAL_CH_W-1:0] <= cmd_byte[7:4];
                  byte_idx                <= 2'd0;
               end
            endcase
         end else if (to_expire) begin
            byte_idx <= 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_vga_cmd_sched.sv
// Bench for vga_cmd_sched: directed scenarios plus a randomized command stream checked against a command-level model.
module tb_vga_cmd_sched;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        cmdreg_data_avail = 1'b0;
   logic [7:0]  cmdreg_data_recv = 8'h00;
   logic        cmdreg_rd;
   logic        blank_in = 1'b1;
   logic        frame_start_in = 1'b0;
   logic        pal_wr;
   logic [3:0]  pal_waddr;
   logic [11:0] pal_wdata;
   logic [3:0]  mode_out;
   logic        busy;
   logic        err;

   int          tests_run = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [7:0]  tx_q[$];
   int          gap_max = 0;
   int          gap = 0;
   int          rd_cnt = 0;
   int          rd_wide = 0;
   int          pal_wide = 0;
   int          blank_viol = 0;
   int          last_rd_cyc = 0;
   int          last_wr_cyc = 0;
   logic [15:0] wr_q[$];
   logic        blank_edge = 1'b0;
   logic        prev_rd = 1'b0;
   logic        prev_wr = 1'b0;

   vga_cmd_sched #(.TIMEOUT(TO), .CNT_W(16)) dut (
      .clk               (clk),
      .nrst              (nrst),
      .cmdreg_data_avail (cmdreg_data_avail),
      .cmdreg_data_recv  (cmdreg_data_recv),
      .cmdreg_rd         (cmdreg_rd),
      .blank_in          (blank_in),
      .frame_start_in    (frame_start_in),
      .pal_wr            (pal_wr),
      .pal_waddr         (pal_waddr),
      .pal_wdata         (pal_wdata),
      .mode_out          (mode_out),
      .busy              (busy),
      .err               (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      blank_edge <= blank_in;
   end

   // Observe strobes and palette writes once per cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (cmdreg_rd === 1'b1) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (prev_rd) rd_wide++;
         end
         prev_rd = (cmdreg_rd === 1'b1);
         if (pal_wr === 1'b1) begin
            wr_q.push_back({pal_waddr, pal_wdata});
            last_wr_cyc = cyc;
            if (prev_wr) pal_wide++;
            if (!blank_edge) blank_viol++;
         end
         prev_wr = (pal_wr === 1'b1);
      end
   end

   // Shared-register model: holds a byte until strobed, then offers the next after a gap.
   initial begin
      forever begin
         @(negedge clk);
         if (cmdreg_data_avail && cmdreg_rd === 1'b1) cmdreg_data_avail = 1'b0;
         if (!cmdreg_data_avail) begin
            if (gap > 0) begin
               gap--;
            end else if (tx_q.size() > 0) begin
               cmdreg_data_recv  = tx_q.pop_front();
               cmdreg_data_avail = 1'b1;
               gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required below 500000", $time);
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (!(tx_q.size() == 0 && !cmdreg_data_avail && busy === 1'b0) && n < max) begin
         tick();
         n++;
      end
      if (n >= max) begin
         tests_run++;
         fails++;
         $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic wait_rd(input int target, input int max);
      int n = 0;
      while (rd_cnt < target && n < max) begin
         tick();
         n++;
      end
      if (n >= max) begin
         tests_run++;
         fails++;
         $display("FAIL wait_rd: rd count %0d, required %0d", rd_cnt, target);
      end
   endtask

   task automatic do_reset();
      tick();
      nrst = 1'b0;
      tx_q.delete();
      cmdreg_data_avail = 1'b0;
      gap = 0;
      tick();
      tick();
      nrst = 1'b1;
      tick();
      wr_q.delete();
   endtask

   task automatic test_reset();
      #1 nrst = 1'b0;
      #3;
      tests_run++;
      if ({cmdreg_rd, pal_wr, busy, err} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags: rd/wr/busy/err=%b required 0000", {cmdreg_rd, pal_wr, busy, err});
      end
      tests_run++;
      if ({pal_waddr, pal_wdata, mode_out} !== 20'h0) begin
         fails++;
         $display("FAIL reset_data: addr/data/mode=%h required 0", {pal_waddr, pal_wdata, mode_out});
      end
      tick();
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_setpal_blank();
      int base = rd_cnt;
      blank_in = 1'b1;
      wr_q.delete();
      tx_q.push_back(8'h15); tx_q.push_back(8'hAB); tx_q.push_back(8'hC7);
      wait_idle(200);
      tests_run++;
      if (wr_q.size() != 1) begin
         fails++;
         $display("FAIL setpal_count: %0d writes, required 1", wr_q.size());
      end else begin
         tests_run++;
         if (wr_q[0] !== 16'h5ABC) begin
            fails++;
            $display("FAIL setpal_data: addr/data=%h required 5abc", wr_q[0]);
         end
      end
      tests_run++;
      if (rd_cnt - base != 3 || rd_wide != 0) begin
         fails++;
         $display("FAIL setpal_rd: strobes=%0d wide=%0d required 3 and 0", rd_cnt - base, rd_wide);
      end
      tests_run++;
      if (last_wr_cyc - last_rd_cyc != 2 || pal_wide != 0) begin
         fails++;
         $display("FAIL setpal_latency: %0d cycles wide=%0d required 2 and 0", last_wr_cyc - last_rd_cyc, pal_wide);
      end
   endtask

   task automatic test_defer();
      int base = rd_cnt;
      blank_in = 1'b0;
      wr_q.delete();
      tx_q.push_back(8'h13); tx_q.push_back(8'h12); tx_q.push_back(8'h30); tx_q.push_back(8'h00);
      for (int i = 0; i < 60; i++) tick();
      tests_run++;
      if (busy !== 1'b1 || wr_q.size() != 0) begin
         fails++;
         $display("FAIL defer_hold: busy=%b writes=%0d required 1 and 0", busy, wr_q.size());
      end
      tests_run++;
      if (rd_cnt - base != 3 || cmdreg_data_avail !== 1'b1) begin
         fails++;
         $display("FAIL defer_stall: strobes=%0d avail=%b required 3 and 1", rd_cnt - base, cmdreg_data_avail);
      end
      blank_in = 1'b1;
      tick();
      tests_run++;
      if (pal_wr !== 1'b1) begin
         fails++;
         $display("FAIL defer_release: pal_wr=%b required 1", pal_wr);
      end
      wait_idle(100);
      tests_run++;
      if (wr_q.size() != 1 || wr_q[0] !== 16'h3123 || rd_cnt - base != 4) begin
         fails++;
         $display("FAIL defer_data: writes=%0d first=%h strobes=%0d required 1, 3123, 4",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 16'hxxxx, rd_cnt - base);
      end
   endtask

   task automatic pulse_frame();
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
   endtask

   task automatic test_mode();
      tx_q.push_back(8'h27);
      wait_idle(100);
      tests_run++;
      if (mode_out !== 4'h0) begin
         fails++;
         $display("FAIL mode_shadowed: mode=%h required 0", mode_out);
      end
      pulse_frame();
      tests_run++;
      if (mode_out !== 4'h7) begin
         fails++;
         $display("FAIL mode_frame: mode=%h required 7", mode_out);
      end
      tx_q.push_back(8'h25);
      wait_idle(100);
      tx_q.push_back(8'h2A);
      wait_rd(rd_cnt + 1, 100);
      pulse_frame();
      tests_run++;
      if (mode_out !== 4'h5) begin
         fails++;
         $display("FAIL mode_same_edge: mode=%h required 5", mode_out);
      end
      wait_idle(100);
      pulse_frame();
      tests_run++;
      if (mode_out !== 4'hA) begin
         fails++;
         $display("FAIL mode_next_frame: mode=%h required a", mode_out);
      end
   endtask

   task automatic test_timeout();
      int base = rd_cnt;
      blank_in = 1'b1;
      wr_q.delete();
      tx_q.push_back(8'h14); tx_q.push_back(8'h55);
      wait_rd(base + 2, 100);
      for (int i = 0; i < TO - 4; i++) tick();
      tests_run++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL timeout_early: err=%b busy=%b required 0 and 1", err, busy);
      end
      for (int i = 0; i < 8; i++) tick();
      tests_run++;
      if (err !== 1'b1 || busy !== 1'b0 || wr_q.size() != 0) begin
         fails++;
         $display("FAIL timeout_abort: err=%b busy=%b writes=%0d required 1, 0, 0", err, busy, wr_q.size());
      end
      tx_q.push_back(8'hFF);
      wait_idle(100);
      tests_run++;
      if (err !== 1'b0) begin
         fails++;
         $display("FAIL clr_err: err=%b required 0", err);
      end
   endtask

   task automatic test_bad_and_reset();
      int base = rd_cnt;
      int nw;
      tx_q.push_back(8'h80);
      wait_idle(100);
      tests_run++;
      if (err !== 1'b1 || busy !== 1'b0 || rd_cnt - base != 1) begin
         fails++;
         $display("FAIL bad_opcode: err=%b busy=%b strobes=%0d required 1, 0, 1", err, busy, rd_cnt - base);
      end
      blank_in = 1'b0;
      tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
      wait_rd(base + 4, 100);
      for (int i = 0; i < 5; i++) tick();
      nw = wr_q.size();
      nrst = 1'b0;
      #1;
      tests_run++;
      if ({cmdreg_rd, pal_wr, busy, err} !== 4'b0000 || {pal_waddr, pal_wdata, mode_out} !== 20'h0) begin
         fails++;
         $display("FAIL reset_mid: flags=%b addr/data/mode=%h required 0000 and 0",
                  {cmdreg_rd, pal_wr, busy, err}, {pal_waddr, pal_wdata, mode_out});
      end
      tx_q.delete();
      cmdreg_data_avail = 1'b0;
      blank_in = 1'b1;
      tick();
      tick();
      nrst = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      tests_run++;
      if (wr_q.size() != nw) begin
         fails++;
         $display("FAIL reset_abandon: %0d writes after reset, required 0", wr_q.size() - nw);
      end
   endtask

   task automatic test_random();
      logic [15:0] exp_wr[$];
      logic        exp_err = 1'b0;
      logic [3:0]  exp_shadow = 4'h0;
      logic [7:0]  op, b1, b2;
      int          n = 0;
      do_reset();
      gap_max = 4;
      rd_wide = 0;
      pal_wide = 0;
      blank_viol = 0;
      for (int c = 0; c < 40; c++) begin
         case ($urandom_range(0, 4))
            0:       op = 8'h00;
            1:       op = {4'h1, 4'($urandom_range(0, 15))};
            2:       op = {4'h2, 4'($urandom_range(0, 15))};
            3:       op = 8'hFF;
            default: op = 8'($urandom_range(0, 255));
         endcase
         tx_q.push_back(op);
         if (op == 8'hFF) begin
            exp_err = 1'b0;
         end else if (op == 8'h00) begin
            exp_err = exp_err;
         end else if (op[7:4] == 4'h1) begin
            b1 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            tx_q.push_back(b1);
            tx_q.push_back(b2);
            exp_wr.push_back({op[3:0], b1, b2[7:4]});
         end else if (op[7:4] == 4'h2) begin
            exp_shadow = op[3:0];
         end else begin
            exp_err = 1'b1;
         end
      end
      while (!(tx_q.size() == 0 && !cmdreg_data_avail && busy === 1'b0) && n < 20000) begin
         blank_in = ($urandom_range(0, 2) == 0);
         tick();
         n++;
      end
      blank_in = 1'b1;
      wait_idle(200);
      tests_run++;
      if (wr_q.size() != exp_wr.size()) begin
         fails++;
         $display("FAIL rand_write_count: %0d writes, required %0d", wr_q.size(), exp_wr.size());
      end
      for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
         tests_run++;
         if (wr_q[i] !== exp_wr[i]) begin
            fails++;
            $display("FAIL rand_write[%0d]: addr/data=%h required %h", i, wr_q[i], exp_wr[i]);
         end
      end
      tests_run++;
      if (err !== exp_err) begin
         fails++;
         $display("FAIL rand_err: err=%b required %b", err, exp_err);
      end
      tests_run++;
      if (blank_viol != 0 || rd_wide != 0 || pal_wide != 0) begin
         fails++;
         $display("FAIL rand_pulses: blank_viol=%0d rd_wide=%0d wr_wide=%0d required all 0",
                  blank_viol, rd_wide, pal_wide);
      end
      pulse_frame();
      tests_run++;
      if (mode_out !== exp_shadow) begin
         fails++;
         $display("FAIL rand_mode: mode=%h required %h", mode_out, exp_shadow);
      end
      gap_max = 0;
   endtask

   initial begin
      test_reset();
      test_setpal_blank();
      test_defer();
      test_mode();
      test_timeout();
      test_bad_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
